// File: rtl/wb_regfile.sv
// Write-back register file: 32x32 GPRs with bypassed read ports,
// sticky halt and a post-halt debug dump sequencer.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clk_en,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [DATA_W-1:0] i_wb_alu_result,
  input  logic              i_wb_mem_to_reg,
  input  logic              i_wb_reg_write,
  input  logic [ADDR_W-1:0] i_wb_rd,
  input  logic              i_wb_halt,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [DATA_W-1:0] o_wb_write_data,
  output logic              o_halted,
  input  logic              i_dbg_dump,
  output logic              o_dbg_valid,
  output logic [ADDR_W-1:0] o_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic              o_dump_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DUMP,
    S_DONE
  } state_e;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              halted_q, halted_d;
  logic              dbg_valid_q, dbg_valid_d;
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] wdata;
  logic              we;

  assign wdata = i_wb_mem_to_reg ? i_wb_data : i_wb_alu_result;
  assign we    = i_clk_en & i_wb_reg_write
               & (i_wb_rd != '0) & ~halted_q;

  assign o_wb_write_data = wdata;
  assign o_halted        = halted_q;
  assign o_dbg_valid     = dbg_valid_q;
  assign o_dbg_addr      = dbg_addr_q;
  assign o_dbg_data      = dbg_data_q;
  assign o_dump_done     = done_q;

  // Index 0 is hardwired; a same-cycle commit wins over the array.
  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] idx
  );
    logic [DATA_W-1:0] v;
    v = regs_q[idx];
    if (idx == '0)
      v = '0;
    else if (we && (i_wb_rd == idx))
      v = wdata;
    return v;
  endfunction

  assign o_rs_data = rd_port(i_rs_addr);
  assign o_rt_data = rd_port(i_rt_addr);

  always_comb begin
    regs_d = regs_q;
    if (we)
      regs_d[i_wb_rd] = wdata;
  end

  always_comb begin
    halted_d = halted_q | (i_clk_en & i_wb_halt);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dbg_valid_d = 1'b0;
    dbg_addr_d  = dbg_addr_q;
    dbg_data_d  = dbg_data_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_dbg_dump) begin
          state_d = S_DUMP;
          idx_d   = '0;
        end
      end
      S_DUMP: begin
        dbg_valid_d = 1'b1;
        dbg_addr_d  = idx_q;
        dbg_data_d  = regs_q[idx_q];
        idx_d       = idx_q + 1'b1;
        if (idx_q == ADDR_W'(NREGS - 1))
          state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
      state_q     <= S_IDLE;
      idx_q       <= '0;
      halted_q    <= 1'b0;
      dbg_valid_q <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      halted_q    <= halted_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_data_q  <= dbg_data_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [31:0] wb_data = '0;
  logic [31:0] alu = '0;
  logic        m2r = 1'b0;
  logic        rw = 1'b0;
  logic [4:0]  rd = '0;
  logic        halt = 1'b0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [31:0] rs_data, rt_data, wbw;
  logic        halted;
  logic        dump = 1'b0;
  logic        dvalid;
  logic [4:0]  daddr;
  logic [31:0] ddata;
  logic        done;

  always #5 clk = ~clk;

  wb_regfile dut (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en),
    .i_wb_data(wb_data), .i_wb_alu_result(alu),
    .i_wb_mem_to_reg(m2r), .i_wb_reg_write(rw),
    .i_wb_rd(rd), .i_wb_halt(halt),
    .i_rs_addr(rs), .i_rt_addr(rt),
    .o_rs_data(rs_data), .o_rt_data(rt_data),
    .o_wb_write_data(wbw), .o_halted(halted),
    .i_dbg_dump(dump), .o_dbg_valid(dvalid),
    .o_dbg_addr(daddr), .o_dbg_data(ddata),
    .o_dump_done(done)
  );

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] wb;
    logic        halted;
    logic        dvalid;
  } rd_exp_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  rd_exp_t rd_q[$];
  beat_t   beat_q[$];
  int      done_exp = 0;
  logic    chk = 1'b0;
  int      checks = 0;
  int      errors = 0;

  // Monitor: pops whenever the DUT presents something observable.
  always @(negedge clk) begin
    if (chk) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL read_q_empty");
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        if (rs_data !== e.rs || rt_data !== e.rt || wbw !== e.wb
            || halted !== e.halted || dvalid !== e.dvalid) begin
          errors++;
          $display("FAIL read#%0d got rs=%h rt=%h wb=%h h=%b v=%b exp rs=%h rt=%h wb=%h h=%b v=%b",
                   e.tag, rs_data, rt_data, wbw, halted, dvalid,
                   e.rs, e.rt, e.wb, e.halted, e.dvalid);
        end
      end
    end
    if (dvalid === 1'b1) begin
      checks++;
      if (beat_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got addr=%0d data=%h", daddr, ddata);
      end else begin
        beat_t b;
        b = beat_q.pop_front();
        if (daddr !== b.addr || ddata !== b.data) begin
          errors++;
          $display("FAIL beat got addr=%0d data=%h exp addr=%0d data=%h",
                   daddr, ddata, b.addr, b.data);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (done_exp == 0 || beat_q.size() != 0) begin
        errors++;
        $display("FAIL dump_done got pulse exp none (pending beats %0d)",
                 beat_q.size());
      end else begin
        done_exp--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic expect_rd(input logic [7:0] tag,
                           input logic [31:0] e_rs,
                           input logic [31:0] e_rt,
                           input logic [31:0] e_wb,
                           input logic e_h,
                           input logic e_v);
    rd_q.push_back({tag, e_rs, e_rt, e_wb, e_h, e_v});
    chk = 1'b1;
  endtask

  task automatic push_dump(input int n, input bit with_done);
    for (int i = 0; i < n; i++)
      beat_q.push_back({5'(i), 32'(i * 32'h11)});
    if (with_done)
      done_exp++;
  endtask

  initial begin
    bit seen;

    // Reset state
    step();
    rs = 5'd5; rt = 5'd31;
    expect_rd(8'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0;

    // 1: ALU commit, same-cycle bypass then array read
    rd = 5'd5; alu = 32'h0000_1234; rw = 1'b1; rs = 5'd5; rt = 5'd0;
    expect_rd(8'd1, 32'h1234, 32'h0, 32'h1234, 1'b0, 1'b0);
    step();
    rw = 1'b0; alu = '0;
    expect_rd(8'd2, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    // 2: r0 write discarded
    rd = 5'd0; alu = 32'hFFFF_FFFF; rw = 1'b1; rs = 5'd0; rt = 5'd0;
    expect_rd(8'd3, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step();
    rw = 1'b0;
    expect_rd(8'd4, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step();

    // 3: memory-data commit, both ports bypass
    rd = 5'd7; m2r = 1'b1; wb_data = 32'hDEAD_BEEF; rw = 1'b1;
    rs = 5'd7; rt = 5'd7;
    expect_rd(8'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step();
    rw = 1'b0; m2r = 1'b0; alu = '0; rt = 5'd5;
    expect_rd(8'd6, 32'hDEAD_BEEF, 32'h1234, 32'h0, 1'b0, 1'b0);
    step();

    // 4: clk_en gating, then halt
    clk_en = 1'b0; rw = 1'b1; rd = 5'd3; alu = 32'h33; rs = 5'd3; rt = 5'd3;
    expect_rd(8'd7, 32'h0, 32'h0, 32'h33, 1'b0, 1'b0);
    step();
    clk_en = 1'b1; rw = 1'b0;
    expect_rd(8'd8, 32'h0, 32'h0, 32'h33, 1'b0, 1'b0);
    step();
    halt = 1'b1; rw = 1'b1; rd = 5'd4; alu = 32'h44; rs = 5'd4; rt = 5'd4;
    expect_rd(8'd9, 32'h44, 32'h44, 32'h44, 1'b0, 1'b0);
    step();
    halt = 1'b0; alu = 32'h99;
    expect_rd(8'd10, 32'h44, 32'h44, 32'h99, 1'b1, 1'b0);
    step();
    rd = 5'd5; rs = 5'd5;
    expect_rd(8'd11, 32'h1234, 32'h44, 32'h99, 1'b1, 1'b0);
    step();
    rw = 1'b0;

    // 5: reset, fill regs[i]=i*0x11, full dump
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_rd(8'd12, 32'h0, 32'h0, 32'h99, 1'b0, 1'b0);
    step();
    for (int i = 1; i < 32; i++) begin
      rd = 5'(i); alu = 32'(i * 32'h11); rw = 1'b1;
      step();
    end
    rw = 1'b0; alu = '0;
    rs = 5'd31; rt = 5'd10;
    expect_rd(8'd13, 32'h20F, 32'hAA, 32'h0, 1'b0, 1'b0);
    push_dump(32, 1'b1);
    dump = 1'b1;
    step();
    dump = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL dump_timeout got no done exp done within 100 cycles");
    end
    step();
    step();

    // 6: reset on beat 10 aborts the dump
    push_dump(11, 1'b0);
    dump = 1'b1;
    step();
    dump = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (dvalid === 1'b1 && daddr == 5'd10) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL beat10_timeout got none exp beat 10");
    end
    #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rs = 5'd5; rt = 5'd31;
    expect_rd(8'd14, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    rs = 5'd11; rt = 5'd1;
    expect_rd(8'd15, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int c = 0; c < 40; c++)
      step();

    checks++;
    if (beat_q.size() != 0 || done_exp != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got beats=%0d done=%0d reads=%0d exp 0",
               beat_q.size(), done_exp, rd_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
